// File: rtl/msi_irq_scheduler_pkg.sv
// MSI interrupt scheduler: shared state encoding, widths and index helper.
// Used by msi_irq_scheduler, its arbiter and its bus interface.
package msi_irq_scheduler_pkg;

  localparam int MaxInterrupts_Con = 32;
  localparam int VectorWidth_Con = 5;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StArb       = 3'd1,
    StReq       = 3'd2,
    StWaitGrant = 3'd3,
    StHoldoff   = 3'd4
  } schedState_t;

  function automatic logic [VectorWidth_Con-1:0] wrapInc(
    input logic [VectorWidth_Con-1:0] idx,
    input int unsigned count
  );
    if ({27'd0, idx} >= count - 32'd1)
      return '0;
    return idx + 5'd1;
  endfunction

endpackage

// File: rtl/msi_irq_scheduler_if.sv
// MSI request/grant handshake between the scheduler and the PCIe bridge.
// master = scheduler side, slave = bridge side.
interface msi_irq_scheduler_if;
  import msi_irq_scheduler_pkg::*;

  logic                       MsiReq_ValOut;
  logic [VectorWidth_Con-1:0] MsiVectorNum_DatOut;
  logic                       MsiGrant_ValIn;
  logic                       MsiIrqEnable_EnIn;

  modport master (
    output MsiReq_ValOut,
    output MsiVectorNum_DatOut,
    input  MsiGrant_ValIn,
    input  MsiIrqEnable_EnIn
  );

  modport slave (
    input  MsiReq_ValOut,
    input  MsiVectorNum_DatOut,
    output MsiGrant_ValIn,
    output MsiIrqEnable_EnIn
  );

endinterface

// File: rtl/msi_irq_rr_arbiter.sv
// Round-robin pick: first eligible source at or after the pointer.
// Purely combinational; wraps at NumberOfInterrupts_Gen-1 -> 0.
import msi_irq_scheduler_pkg::*;

module msi_irq_rr_arbiter #(
  parameter int NumberOfInterrupts_Gen = 8
) (
  input  logic [NumberOfInterrupts_Gen-1:0] Eligible_DatIn,
  input  logic [VectorWidth_Con-1:0]        Pointer_DatIn,
  output logic [VectorWidth_Con-1:0]        Index_DatOut,
  output logic                              Valid_ValOut
);

  logic [MaxInterrupts_Con-1:0] padded;
  logic [VectorWidth_Con:0]     cand;

  assign padded = MaxInterrupts_Con'(Eligible_DatIn);

  // Scan farthest offset first so the nearest hit is the one kept.
  always_comb begin
    Index_DatOut = '0;
    Valid_ValOut = 1'b0;
    cand = '0;
    for (int k = NumberOfInterrupts_Gen - 1; k >= 0; k--) begin
      cand = {1'b0, Pointer_DatIn} + 6'(k);
      if (cand >= 6'(NumberOfInterrupts_Gen))
        cand = cand - 6'(NumberOfInterrupts_Gen);
      if (padded[cand[VectorWidth_Con-1:0]]) begin
        Index_DatOut = cand[VectorWidth_Con-1:0];
        Valid_ValOut = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msi_irq_scheduler.sv
// MSI interrupt scheduler: sync, latch, mask, round-robin, grant/timeout, holdoff.
// MSI_IRQ_SCHED_STATS_EN enables the sent/timeout counters (else tied to 0).
import msi_irq_scheduler_pkg::*;

module msi_irq_scheduler #(
  parameter int          NumberOfInterrupts_Gen = 8,
  parameter logic [31:0] LevelInterrupt_Gen     = 32'h0,
  parameter int          HoldoffWidth_Gen       = 16,
  parameter int          GrantTimeout_Gen       = 1024
) (
  input  logic                              SysClk_ClkIn,
  input  logic                              SysRstN_RstIn,
  input  logic [NumberOfInterrupts_Gen-1:0] IrqIn_DatIn,
  input  logic [NumberOfInterrupts_Gen-1:0] IrqMask_DatIn,
  input  logic [HoldoffWidth_Gen-1:0]       Holdoff_DatIn,
  msi_irq_scheduler_if.master               msiBus,
  output logic [NumberOfInterrupts_Gen-1:0] IrqPending_DatOut,
  output logic                              GrantTimeout_EvtOut,
  output logic                              Busy_ValOut,
  output logic [31:0]                       MsiSentCount_CntOut,
  output logic [15:0]                       MsiTimeoutCount_CntOut
);

  localparam int N = NumberOfInterrupts_Gen;
  localparam int ToW = $clog2(GrantTimeout_Gen);
  localparam logic [N-1:0] LevelMask_Con = LevelInterrupt_Gen[N-1:0];

  logic [N-1:0] sync1, sync2, dly, pending;
  logic [N-1:0] setVec, clrVec, eligible;

  schedState_t               state;
  logic                      reqQ, evtQ;
  logic [VectorWidth_Con-1:0] vecQ, ptrQ;
  logic [ToW-1:0]            toCnt;
  logic [HoldoffWidth_Gen-1:0] hoCnt;

  logic                      en, grant, grantHit;
  logic [VectorWidth_Con-1:0] arbIdx;
  logic                      arbValid;

  assign en = msiBus.MsiIrqEnable_EnIn;
  assign grant = msiBus.MsiGrant_ValIn;
  assign grantHit = en && (state == StWaitGrant) && grant;

  assign setVec = sync2 & (LevelMask_Con | ~dly);
  assign clrVec = grantHit ? (N'(1) << vecQ) : '0;
  assign eligible = pending & ~IrqMask_DatIn;

  msi_irq_rr_arbiter #(
    .NumberOfInterrupts_Gen(N)
  ) uArb (
    .Eligible_DatIn(eligible),
    .Pointer_DatIn (ptrQ),
    .Index_DatOut  (arbIdx),
    .Valid_ValOut  (arbValid)
  );

  // Set wins over clear so a level source re-latches on its own grant.
  always_ff @(posedge SysClk_ClkIn or posedge SysRstN_RstIn) begin
    if (SysRstN_RstIn) begin
      sync1 <= '0;
      sync2 <= '0;
      dly <= '0;
      pending <= '0;
    end else if (!en) begin
      sync1 <= '0;
      sync2 <= '0;
      dly <= '0;
      pending <= '0;
    end else begin
      sync1 <= IrqIn_DatIn;
      sync2 <= sync1;
      dly <= sync2;
      pending <= (pending & ~clrVec) | setVec;
    end
  end

  always_ff @(posedge SysClk_ClkIn or posedge SysRstN_RstIn) begin
    if (SysRstN_RstIn) begin
      state <= StIdle;
      reqQ <= 1'b0;
      evtQ <= 1'b0;
      vecQ <= '0;
      ptrQ <= '0;
      toCnt <= '0;
      hoCnt <= '0;
    end else if (!en) begin
      state <= StIdle;
      reqQ <= 1'b0;
      evtQ <= 1'b0;
    end else begin
      reqQ <= 1'b0;
      evtQ <= 1'b0;
      unique case (state)
        StIdle: begin
          if (|eligible)
            state <= StArb;
        end
        StArb: begin
          if (arbValid) begin
            vecQ <= arbIdx;
            reqQ <= 1'b1;
            state <= StReq;
          end else begin
            state <= StIdle;
          end
        end
        StReq: begin
          toCnt <= ToW'(GrantTimeout_Gen - 1);
          state <= StWaitGrant;
        end
        StWaitGrant: begin
          if (grant) begin
            ptrQ <= wrapInc(vecQ, N);
            hoCnt <= Holdoff_DatIn;
            state <= StHoldoff;
          end else if (toCnt == '0) begin
            evtQ <= 1'b1;
            hoCnt <= Holdoff_DatIn;
            state <= StHoldoff;
          end else begin
            toCnt <= toCnt - 1'b1;
          end
        end
        StHoldoff: begin
          if (hoCnt == '0)
            state <= StIdle;
          else
            hoCnt <= hoCnt - 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign msiBus.MsiReq_ValOut = reqQ;
  assign msiBus.MsiVectorNum_DatOut = vecQ;
  assign IrqPending_DatOut = pending;
  assign GrantTimeout_EvtOut = evtQ;
  assign Busy_ValOut = (state != StIdle);

`ifdef MSI_IRQ_SCHED_STATS_EN
  logic        toHit;
  logic [31:0] sentCnt;
  logic [15:0] toCntTot;

  assign toHit = en && (state == StWaitGrant) && !grant && (toCnt == '0);

  always_ff @(posedge SysClk_ClkIn or posedge SysRstN_RstIn) begin
    if (SysRstN_RstIn) begin
      sentCnt <= '0;
      toCntTot <= '0;
    end else begin
      if (grantHit && (sentCnt != '1))
        sentCnt <= sentCnt + 32'd1;
      if (toHit && (toCntTot != '1))
        toCntTot <= toCntTot + 16'd1;
    end
  end

  assign MsiSentCount_CntOut = sentCnt;
  assign MsiTimeoutCount_CntOut = toCntTot;
`else
  assign MsiSentCount_CntOut = '0;
  assign MsiTimeoutCount_CntOut = '0;
`endif

endmodule

// File: tb/tb_msi_irq_scheduler.sv
// Bench for msi_irq_scheduler: directed scenarios with randomized rounds,
// checked against a list-based round-robin model of the message order.
module tb_msi_irq_scheduler;

  localparam int N = 8;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq = '0;
  logic [7:0]  mask = '0;
  logic [15:0] hold = '0;
  logic [7:0]  pend;
  logic        evt, busy;
  logic [31:0] sentCnt;
  logic [15:0] toCnt;

  msi_irq_scheduler_if bus ();

  msi_irq_scheduler #(
    .NumberOfInterrupts_Gen(N),
    .LevelInterrupt_Gen    (32'h1),
    .HoldoffWidth_Gen      (16),
    .GrantTimeout_Gen      (TO)
  ) dut (
    .SysClk_ClkIn          (clk),
    .SysRstN_RstIn         (rst),
    .IrqIn_DatIn           (irq),
    .IrqMask_DatIn         (mask),
    .Holdoff_DatIn         (hold),
    .msiBus                (bus),
    .IrqPending_DatOut     (pend),
    .GrantTimeout_EvtOut   (evt),
    .Busy_ValOut           (busy),
    .MsiSentCount_CntOut   (sentCnt),
    .MsiTimeoutCount_CntOut(toCnt)
  );

  always #5 clk = ~clk;

  int nPass = 0;
  int nChecks = 0;
  int ptr = 0;
  bit [7:0] mPend = '0;
  int mSent = 0;
  int mTo = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pickNext(input bit [7:0] elig, input int p);
    for (int k = 0; k < N; k++)
      if (elig[(p + k) % N])
        return (p + k) % N;
    return -1;
  endfunction

  task automatic waitReq(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.MsiReq_ValOut !== 1'b1 && n < 300);
    chk("req_seen", 32'(bus.MsiReq_ValOut), 1);
  endtask

  task automatic grantIt(input int d);
    repeat (d) tick();
    bus.MsiGrant_ValIn = 1'b1;
    tick();
    bus.MsiGrant_ValIn = 1'b0;
    mSent++;
    ptr = (int'(bus.MsiVectorNum_DatOut) + 1) % N;
  endtask

  task automatic chkStats(input string tag);
`ifdef MSI_IRQ_SCHED_STATS_EN
    chk({tag, "_sent"}, sentCnt, 32'(mSent));
    chk({tag, "_tocnt"}, 32'(toCnt), 32'(mTo));
`else
    chk({tag, "_sent"}, sentCnt, 0);
    chk({tag, "_tocnt"}, 32'(toCnt), 0);
`endif
  endtask

  // Raise edge lines together from Idle and serve them all with grants.
  task automatic serveRound(input bit [7:0] lines, input int h,
                            input int dFix);
    int n, e, d;
    bit first;
    hold = 16'(h);
    irq = irq | lines;
    mPend = mPend | lines;
    first = 1'b1;
    while (mPend != 0) begin
      e = pickNext(mPend, ptr);
      waitReq(n);
      chk(first ? "lat_first" : "lat_spacing", n, first ? 5 : h + 3);
      chk("vector", 32'(bus.MsiVectorNum_DatOut), 32'(e));
      chk("pend_at_req", 32'(pend), 32'(mPend));
      d = (dFix > 0) ? dFix : $urandom_range(1, 3);
      grantIt(d);
      mPend[e] = 1'b0;
      chk("pend_after_grant", 32'(pend), 32'(mPend));
      chk("busy_holdoff", 32'(busy), 1);
      first = 1'b0;
    end
    repeat (h + 1) tick();
    chk("busy_idle", 32'(busy), 0);
    chkStats("round");
    irq = irq & ~lines;
    repeat (4) tick();
  endtask

  initial begin
    int n, m, e, h;
    bit seen, seenEvt;
    bus.MsiGrant_ValIn = 1'b0;
    bus.MsiIrqEnable_EnIn = 1'b1;

    repeat (3) tick();
    chk("rst_req", 32'(bus.MsiReq_ValOut), 0);
    chk("rst_vec", 32'(bus.MsiVectorNum_DatOut), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_evt", 32'(evt), 0);
    chk("rst_busy", 32'(busy), 0);
    chkStats("rst");
    rst = 1'b0;
    repeat (4) tick();
    chk("idle_busy", 32'(busy), 0);

    // lines 1,5,6 from pointer 0, holdoff 4, immediate grants
    serveRound(8'b0110_0010, 4, 1);

    // single edge on line 3, holdoff 0, grant 2 clocks after request
    serveRound(8'b0000_1000, 0, 2);

    for (int r = 0; r < 4; r++)
      serveRound(8'($urandom_range(1, 127)) << 1, $urandom_range(0, 5), 0);

    // grant timeout and retry of the same vector
    h = $urandom_range(0, 4);
    hold = 16'(h);
    irq[4] = 1'b1;
    mPend[4] = 1'b1;
    e = pickNext(mPend, ptr);
    waitReq(n);
    chk("to_lat", n, 5);
    chk("to_vec", 32'(bus.MsiVectorNum_DatOut), 32'(e));
    m = 0;
    do begin
      tick();
      m++;
    end while (evt !== 1'b1 && m < 100);
    chk("to_delay", m, TO + 1);
    mTo++;
    chk("to_pend", 32'(pend), 32'(mPend));
    tick();
    chk("to_pulse_width", 32'(evt), 0);
    waitReq(n);
    chk("retry_spacing", n, h + 2);
    chk("retry_vec", 32'(bus.MsiVectorNum_DatOut), 32'(e));
    grantIt(1);
    mPend[4] = 1'b0;
    chk("retry_pend", 32'(pend), 32'(mPend));
    irq[4] = 1'b0;
    repeat (h + 6) tick();
    chkStats("timeout");

    // masked source latches but is not sent until unmasked
    mask = 8'h04;
    irq[2] = 1'b1;
    mPend[2] = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (bus.MsiReq_ValOut === 1'b1) seen = 1'b1;
    end
    chk("mask_noreq", 32'(seen), 0);
    chk("mask_pend", 32'(pend), 32'h04);
    mask = 8'h00;
    waitReq(n);
    chk("unmask_lat", n, 2);
    chk("unmask_vec", 32'(bus.MsiVectorNum_DatOut), 2);
    grantIt(1);
    mPend[2] = 1'b0;
    irq[2] = 1'b0;
    repeat (8) tick();
    chkStats("mask");

    // enable dropped while waiting for the grant
    irq[6] = 1'b1;
    mPend[6] = 1'b1;
    waitReq(n);
    chk("en_vec", 32'(bus.MsiVectorNum_DatOut), 32'(pickNext(mPend, ptr)));
    tick();
    bus.MsiIrqEnable_EnIn = 1'b0;
    tick();
    mPend = '0;
    chk("en_busy", 32'(busy), 0);
    chk("en_req", 32'(bus.MsiReq_ValOut), 0);
    chk("en_pend", 32'(pend), 0);
    irq[6] = 1'b0;
    seen = 1'b0;
    seenEvt = 1'b0;
    repeat (20) begin
      tick();
      if (evt === 1'b1) seenEvt = 1'b1;
      if (bus.MsiReq_ValOut === 1'b1) seen = 1'b1;
    end
    bus.MsiIrqEnable_EnIn = 1'b1;
    repeat (20) begin
      tick();
      if (evt === 1'b1) seenEvt = 1'b1;
      if (bus.MsiReq_ValOut === 1'b1) seen = 1'b1;
    end
    chk("en_no_evt", 32'(seenEvt), 0);
    chk("en_no_req", 32'(seen), 0);
    chkStats("enable");

    // level source 0 held high re-latches after each grant
    h = $urandom_range(0, 3);
    hold = 16'(h);
    irq[0] = 1'b1;
    mPend[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waitReq(n);
      chk("lvl_spacing", n, (i == 0) ? 5 : h + 3);
      chk("lvl_vec", 32'(bus.MsiVectorNum_DatOut), 32'(pickNext(mPend, ptr)));
      if (i == 2) begin
        irq[0] = 1'b0;
        grantIt(3);
        mPend[0] = 1'b0;
      end else begin
        grantIt(1);
      end
      chk("lvl_pend", 32'(pend), 32'(mPend));
      chkStats("lvl");
    end
    seen = 1'b0;
    repeat (h + 10) begin
      tick();
      if (bus.MsiReq_ValOut === 1'b1) seen = 1'b1;
    end
    chk("lvl_quiet", 32'(seen), 0);
    chk("final_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
